// File: rtl/imu_i2c_sequencer.sv
// imu_i2c_sequencer
// Drives a byte-level I2C master for an MPU6050: writes the init table after
// reset, then runs one burst read per data-ready interrupt edge and publishes
// the assembled sample. One command outstanding at a time, with a response timeout.
module imu_i2c_sequencer #(
    parameter logic [6:0] DEV_ADDR  = 7'h68,
    parameter logic [7:0] START_REG = 8'h3B,
    parameter int         NUM_BYTES = 14,
    parameter int         TIMEOUT   = 50000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         signal_INT,
    output logic         cmd_valid,
    input  logic         cmd_ready,
    output logic [2:0]   cmd_op,
    output logic [7:0]   cmd_wdata,
    input  logic         rsp_valid,
    input  logic [7:0]   rsp_rdata,
    input  logic         rsp_nack,
    output logic [111:0] sample_data,
    output logic         sample_valid,
    output logic         init_done,
    output logic         busy,
    output logic         err_nack,
    output logic         err_timeout,
    output logic         overrun
);

    localparam logic [2:0] OP_START     = 3'd0;
    localparam logic [2:0] OP_WRITE     = 3'd1;
    localparam logic [2:0] OP_READ_ACK  = 3'd2;
    localparam logic [2:0] OP_READ_NACK = 3'd3;
    localparam logic [2:0] OP_STOP      = 3'd4;

    localparam int TW    = $clog2(TIMEOUT + 1);
    // Staging fills from the LSB end; shift so byte 0 lands in [111:104].
    localparam int ALIGN = 8 * (14 - NUM_BYTES);

    typedef enum logic [3:0] {
        ST_INIT_START, ST_INIT_ADDR, ST_INIT_REG, ST_INIT_DATA, ST_INIT_STOP,
        ST_IDLE,
        ST_RD_START, ST_RD_ADDR_W, ST_RD_REG, ST_RD_RESTART, ST_RD_ADDR_R,
        ST_RD_BYTE, ST_RD_STOP,
        ST_PUBLISH, ST_ERR_STOP
    } state_t;

    state_t          state_reg;
    logic            wait_rsp_reg;
    logic [TW-1:0]   timer_reg;
    logic [1:0]      idx_reg;
    logic [3:0]      byte_cnt_reg;
    logic [111:0]    staging_reg;
    logic            pending_reg;
    logic [1:0]      int_sync_reg;
    logic            int_prev_reg;

    logic [2:0]      cmd_op_next;
    logic [7:0]      cmd_wdata_next;
    logic            cmd_is_write;
    logic [15:0]     init_cur;
    logic            int_rise;
    logic            pend_consume;

    // Init table entries as {register, data}.
    function automatic logic [15:0] init_entry(input logic [1:0] idx);
        case (idx)
            2'd0:    init_entry = 16'h6B00;
            2'd1:    init_entry = 16'h1907;
            default: init_entry = 16'h3801;
        endcase
    endfunction

    assign init_cur     = init_entry(idx_reg);
    assign int_rise     = int_sync_reg[1] & ~int_prev_reg;
    assign pend_consume = (state_reg == ST_IDLE) && pending_reg;

    // Command each state issues, decoded from state and counters.
    always_comb begin
        cmd_op_next    = OP_STOP;
        cmd_wdata_next = 8'h00;
        cmd_is_write   = 1'b0;
        case (state_reg)
            ST_INIT_START, ST_RD_START, ST_RD_RESTART: cmd_op_next = OP_START;
            ST_INIT_ADDR, ST_RD_ADDR_W: begin
                cmd_op_next    = OP_WRITE;
                cmd_wdata_next = {DEV_ADDR, 1'b0};
                cmd_is_write   = 1'b1;
            end
            ST_INIT_REG: begin
                cmd_op_next    = OP_WRITE;
                cmd_wdata_next = init_cur[15:8];
                cmd_is_write   = 1'b1;
            end
            ST_INIT_DATA: begin
                cmd_op_next    = OP_WRITE;
                cmd_wdata_next = init_cur[7:0];
                cmd_is_write   = 1'b1;
            end
            ST_RD_REG: begin
                cmd_op_next    = OP_WRITE;
                cmd_wdata_next = START_REG;
                cmd_is_write   = 1'b1;
            end
            ST_RD_ADDR_R: begin
                cmd_op_next    = OP_WRITE;
                cmd_wdata_next = {DEV_ADDR, 1'b1};
                cmd_is_write   = 1'b1;
            end
            ST_RD_BYTE: cmd_op_next = (byte_cnt_reg == 4'(NUM_BYTES - 1)) ? OP_READ_NACK : OP_READ_ACK;
            default: cmd_op_next = OP_STOP;
        endcase
    end

    // Sequencer FSM: interrupt sync, pending flag, command handshake and sample publish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_INIT_START;
            wait_rsp_reg <= 1'b0;
            timer_reg    <= '0;
            idx_reg      <= 2'd0;
            byte_cnt_reg <= 4'd0;
            staging_reg  <= '0;
            pending_reg  <= 1'b0;
            int_sync_reg <= 2'b00;
            int_prev_reg <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_op       <= 3'd0;
            cmd_wdata    <= 8'h00;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            init_done    <= 1'b0;
            busy         <= 1'b0;
            err_nack     <= 1'b0;
            err_timeout  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            busy         <= (state_reg != ST_IDLE);
            int_sync_reg <= {int_sync_reg[0], signal_INT};
            int_prev_reg <= int_sync_reg[1];

            // Depth-one request latch; edges before init completes are dropped.
            if (pend_consume) begin
                pending_reg <= int_rise && init_done;
            end else if (int_rise && init_done) begin
                if (pending_reg) begin
                    overrun <= 1'b1;
                end
                pending_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (pending_reg) begin
                        state_reg    <= ST_RD_START;
                        staging_reg  <= '0;
                        byte_cnt_reg <= 4'd0;
                    end
                end
                ST_PUBLISH: state_reg <= ST_IDLE;
                default: begin
                    if (wait_rsp_reg) begin
                        // A response in the expiry cycle wins over the timeout.
                        if (rsp_valid) begin
                            wait_rsp_reg <= 1'b0;
                            if (cmd_is_write && rsp_nack) begin
                                err_nack  <= 1'b1;
                                state_reg <= ST_ERR_STOP;
                            end else begin
                                case (state_reg)
                                    ST_INIT_START: state_reg <= ST_INIT_ADDR;
                                    ST_INIT_ADDR:  state_reg <= ST_INIT_REG;
                                    ST_INIT_REG:   state_reg <= ST_INIT_DATA;
                                    ST_INIT_DATA:  state_reg <= ST_INIT_STOP;
                                    ST_INIT_STOP: begin
                                        if (idx_reg == 2'd2) begin
                                            init_done <= 1'b1;
                                            state_reg <= ST_IDLE;
                                        end else begin
                                            idx_reg   <= idx_reg + 2'd1;
                                            state_reg <= ST_INIT_START;
                                        end
                                    end
                                    ST_RD_START:   state_reg <= ST_RD_ADDR_W;
                                    ST_RD_ADDR_W:  state_reg <= ST_RD_REG;
                                    ST_RD_REG:     state_reg <= ST_RD_RESTART;
                                    ST_RD_RESTART: state_reg <= ST_RD_ADDR_R;
                                    ST_RD_ADDR_R:  state_reg <= ST_RD_BYTE;
                                    ST_RD_BYTE: begin
                                        staging_reg <= {staging_reg[103:0], rsp_rdata};
                                        if (byte_cnt_reg == 4'(NUM_BYTES - 1)) begin
                                            state_reg <= ST_RD_STOP;
                                        end else begin
                                            byte_cnt_reg <= byte_cnt_reg + 4'd1;
                                        end
                                    end
                                    ST_RD_STOP: begin
                                        sample_data  <= staging_reg << ALIGN;
                                        sample_valid <= 1'b1;
                                        state_reg    <= ST_PUBLISH;
                                    end
                                    default: begin
                                        idx_reg   <= 2'd0;
                                        state_reg <= init_done ? ST_IDLE : ST_INIT_START;
                                    end
                                endcase
                            end
                        end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                            // Master presumed hung: abandon the transfer without a STOP.
                            err_timeout  <= 1'b1;
                            wait_rsp_reg <= 1'b0;
                            idx_reg      <= 2'd0;
                            state_reg    <= init_done ? ST_IDLE : ST_INIT_START;
                        end else begin
                            timer_reg <= timer_reg + TW'(1);
                        end
                    end else if (cmd_valid) begin
                        if (cmd_ready) begin
                            cmd_valid    <= 1'b0;
                            wait_rsp_reg <= 1'b1;
                            timer_reg    <= '0;
                        end
                    end else begin
                        cmd_valid <= 1'b1;
                        cmd_op    <= cmd_op_next;
                        cmd_wdata <= cmd_wdata_next;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imu_i2c_sequencer.sv
// Bench for imu_i2c_sequencer: randomized I2C master/slave responder, command log
// compared against an expected transaction list built from the protocol rules.
module tb_imu_i2c_sequencer;

    localparam int TIMEOUT = 50000;
    localparam logic [2:0] OP_START     = 3'd0;
    localparam logic [2:0] OP_WRITE     = 3'd1;
    localparam logic [2:0] OP_READ_ACK  = 3'd2;
    localparam logic [2:0] OP_READ_NACK = 3'd3;
    localparam logic [2:0] OP_STOP      = 3'd4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         signal_INT = 1'b0;
    logic         cmd_valid;
    logic         cmd_ready = 1'b0;
    logic [2:0]   cmd_op;
    logic [7:0]   cmd_wdata;
    logic         rsp_valid = 1'b0;
    logic [7:0]   rsp_rdata = 8'h00;
    logic         rsp_nack = 1'b0;
    logic [111:0] sample_data;
    logic         sample_valid;
    logic         init_done;
    logic         busy;
    logic         err_nack;
    logic         err_timeout;
    logic         overrun;

    always #10 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    imu_i2c_sequencer dut (
        .clk(clk), .rst(rst), .signal_INT(signal_INT),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .sample_data(sample_data), .sample_valid(sample_valid), .init_done(init_done),
        .busy(busy), .err_nack(err_nack), .err_timeout(err_timeout), .overrun(overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] log_q[$];
    logic [10:0] exp_q[$];
    logic [7:0]  slave_q[$];
    int          cmd_total = 0;
    int          nack_at = -1;
    bit          hang = 1'b0;
    int          sv_count = 0;
    logic [111:0] sv_data = '0;
    int unsigned sv_cyc = 0;
    int unsigned stop_rsp_cyc = 0;

    // Responder: accepts commands, logs them, answers after 1..3 cycles.
    initial begin : responder
        int d;
        logic [2:0] op;
        logic [7:0] wd;
        bit held;
        logic [10:0] held_cmd;
        bit aborted;
        held = 1'b0;
        forever begin
            @(negedge clk);
            rsp_valid = 1'b0;
            rsp_nack  = 1'b0;
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    n_checks++;
                    if (!cmd_valid || {cmd_op, cmd_wdata} !== held_cmd) begin
                        n_fail++;
                        $display("FAIL cmd_stable got valid=%0b op/data=%h want valid=1 op/data=%h",
                                 cmd_valid, {cmd_op, cmd_wdata}, held_cmd);
                    end
                end
                cmd_ready = ($urandom_range(0, 3) != 0);
                held      = cmd_valid && !cmd_ready;
                held_cmd  = {cmd_op, cmd_wdata};
                if (cmd_valid && cmd_ready) begin
                    op = cmd_op;
                    wd = cmd_wdata;
                    log_q.push_back({op, (op == OP_WRITE) ? wd : 8'h00});
                    $display("cmd %0d op=%0d data=%h", cmd_total, op, wd);
                    cmd_total++;
                    if (!hang) begin
                        d = $urandom_range(1, 3);
                        aborted = 1'b0;
                        for (int k = 0; k < d; k++) begin
                            @(negedge clk);
                            if (rst) begin
                                aborted = 1'b1;
                            end else if (!aborted) begin
                                n_checks++;
                                if (cmd_valid !== 1'b0) begin
                                    n_fail++;
                                    $display("FAIL one_outstanding got cmd_valid=%0b want 0", cmd_valid);
                                end
                            end
                        end
                        if (!aborted && !rst) begin
                            rsp_valid = 1'b1;
                            rsp_nack  = (op == OP_WRITE) && ((cmd_total - 1) == nack_at);
                            if (op == OP_READ_ACK || op == OP_READ_NACK)
                                rsp_rdata = (slave_q.size() > 0) ? slave_q.pop_front() : 8'($urandom);
                            else
                                rsp_rdata = 8'($urandom);
                            if (op == OP_STOP) stop_rsp_cyc = cyc;
                        end
                    end
                end
            end
        end
    end

    // Sample monitor.
    initial begin : sample_mon
        forever begin
            @(negedge clk);
            if (sample_valid === 1'b1) begin
                sv_count++;
                sv_data = sample_data;
                sv_cyc  = cyc;
                $display("sample %h", sample_data);
            end
        end
    end

    initial begin : watchdog
        #(200000 * 20);
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] c(input logic [2:0] op, input logic [7:0] data);
        return {op, data};
    endfunction

    task automatic exp_init();
        logic [7:0] regs [3];
        logic [7:0] vals [3];
        regs = '{8'h6B, 8'h19, 8'h38};
        vals = '{8'h00, 8'h07, 8'h01};
        for (int e = 0; e < 3; e++) begin
            exp_q.push_back(c(OP_START, 8'h00));
            exp_q.push_back(c(OP_WRITE, 8'hD0));
            exp_q.push_back(c(OP_WRITE, regs[e]));
            exp_q.push_back(c(OP_WRITE, vals[e]));
            exp_q.push_back(c(OP_STOP, 8'h00));
        end
    endtask

    task automatic exp_read_header();
        exp_q.push_back(c(OP_START, 8'h00));
        exp_q.push_back(c(OP_WRITE, 8'hD0));
        exp_q.push_back(c(OP_WRITE, 8'h3B));
        exp_q.push_back(c(OP_START, 8'h00));
        exp_q.push_back(c(OP_WRITE, 8'hD1));
    endtask

    task automatic exp_read_full();
        exp_read_header();
        for (int i = 0; i < 13; i++) exp_q.push_back(c(OP_READ_ACK, 8'h00));
        exp_q.push_back(c(OP_READ_NACK, 8'h00));
        exp_q.push_back(c(OP_STOP, 8'h00));
    endtask

    task automatic pulse_int();
        signal_INT = 1'b1;
        repeat (3) @(negedge clk);
        signal_INT = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (log_q.size() >= n) ok = 1'b1;
            else @(negedge clk);
        end
        if (log_q.size() >= n) ok = 1'b1;
    endtask

    task automatic wait_samples(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (sv_count >= n) ok = 1'b1;
            else @(negedge clk);
        end
        if (sv_count >= n) ok = 1'b1;
    endtask

    task automatic wait_init_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (init_done === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bit ok;
        int base_sv;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cmd_valid, sample_valid, init_done, busy, err_nack, err_timeout, overrun} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 0000000",
                     {cmd_valid, sample_valid, init_done, busy, err_nack, err_timeout, overrun});
        end
        n_checks++;
        if (sample_data !== 112'h0) begin
            n_fail++;
            $display("FAIL reset_sample got %h want 0", sample_data);
        end
        base_sv = sv_count;
        log_q.delete();
        exp_q.delete();
        exp_init();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        pulse_int();  // arrives during init: must be ignored
        wait_log(15, 3000, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL init_cmds got %0d want 15", log_q.size());
        end
        wait_init_done(500, ok);
        n_checks++;
        if (init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL init_done got %b want 1", init_done);
        end
        repeat (100) @(negedge clk);
        n_checks++;
        if (log_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL init_count got %0d want %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL init_cmd[%0d] got %h want %h", i, log_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (sv_count != base_sv || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL init_quiet got samples=%0d busy=%b want samples=0 busy=0", sv_count - base_sv, busy);
        end
    endtask

    task automatic test_single_read(input bit randomize_bytes);
        bit ok;
        int base_sv;
        logic [7:0] b;
        logic [111:0] exp_sample;
        exp_sample = '0;
        slave_q.delete();
        for (int i = 0; i < 14; i++) begin
            b = randomize_bytes ? 8'($urandom) : 8'(i + 1);
            slave_q.push_back(b);
            exp_sample = {exp_sample[103:0], b};
        end
        base_sv = sv_count;
        log_q.delete();
        exp_q.delete();
        exp_read_full();
        pulse_int();
        wait_samples(base_sv + 1, 2000, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL read_sample_wait got %0d samples want 1", sv_count - base_sv);
        end
        repeat (30) @(negedge clk);
        n_checks++;
        if (sv_count != base_sv + 1) begin
            n_fail++;
            $display("FAIL read_pulses got %0d want 1", sv_count - base_sv);
        end
        n_checks++;
        if (sv_data !== exp_sample || sample_data !== exp_sample) begin
            n_fail++;
            $display("FAIL read_data got %h want %h", sample_data, exp_sample);
        end
        n_checks++;
        if (sv_cyc - stop_rsp_cyc != 1) begin
            n_fail++;
            $display("FAIL read_latency got %0d want 1", sv_cyc - stop_rsp_cyc);
        end
        n_checks++;
        if (log_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL read_count got %0d want %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL read_cmd[%0d] got %h want %h", i, log_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_nack();
        bit ok;
        int base_sv;
        logic [111:0] prev;
        n_checks++;
        if (err_nack !== 1'b0) begin
            n_fail++;
            $display("FAIL nack_pre got %b want 0", err_nack);
        end
        prev    = sample_data;
        base_sv = sv_count;
        slave_q.delete();
        log_q.delete();
        exp_q.delete();
        exp_read_header();
        exp_q.push_back(c(OP_STOP, 8'h00));
        nack_at = cmd_total + 4;
        pulse_int();
        wait_log(6, 2000, ok);
        repeat (40) @(negedge clk);
        nack_at = -1;
        n_checks++;
        if (!ok || err_nack !== 1'b1) begin
            n_fail++;
            $display("FAIL nack_flag got %b want 1", err_nack);
        end
        n_checks++;
        if (sample_data !== prev || sv_count != base_sv) begin
            n_fail++;
            $display("FAIL nack_sample got %h pulses=%0d want %h pulses=0", sample_data, sv_count - base_sv, prev);
        end
        n_checks++;
        if (log_q.size() != exp_q.size() || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL nack_count got %0d busy=%b want %0d busy=0", log_q.size(), busy, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL nack_cmd[%0d] got %h want %h", i, log_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt;
        n_checks++;
        if (err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pre got %b want 0", err_timeout);
        end
        hang = 1'b1;
        log_q.delete();
        pulse_int();
        wait_log(1, 2000, ok);
        cnt = 0;
        while (err_timeout !== 1'b1 && cnt < TIMEOUT + 100) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (!ok || cnt < TIMEOUT - 1 || cnt > TIMEOUT + 3) begin
            n_fail++;
            $display("FAIL timeout_cycles got %0d want about %0d", cnt, TIMEOUT + 1);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_idle got valid=%b busy=%b err=%b want 0 0 1", cmd_valid, busy, err_timeout);
        end
        n_checks++;
        if (log_q.size() != 1) begin
            n_fail++;
            $display("FAIL timeout_no_stop got %0d cmds want 1", log_q.size());
        end
        hang = 1'b0;
    endtask

    task automatic test_overrun();
        bit ok;
        int base_sv;
        logic [7:0] b;
        logic [111:0] exp2;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_pre got %b want 0", overrun);
        end
        exp2 = '0;
        slave_q.delete();
        for (int i = 0; i < 28; i++) begin
            b = 8'($urandom);
            slave_q.push_back(b);
            if (i >= 14) exp2 = {exp2[103:0], b};
        end
        base_sv = sv_count;
        log_q.delete();
        exp_q.delete();
        exp_read_full();
        exp_read_full();
        pulse_int();
        wait_log(1, 2000, ok);
        repeat (3) pulse_int();
        wait_samples(base_sv + 2, 4000, ok);
        repeat (200) @(negedge clk);
        n_checks++;
        if (sv_count != base_sv + 2) begin
            n_fail++;
            $display("FAIL overrun_bursts got %0d want 2", sv_count - base_sv);
        end
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_flag got %b want 1", overrun);
        end
        n_checks++;
        if (sample_data !== exp2) begin
            n_fail++;
            $display("FAIL overrun_data got %h want %h", sample_data, exp2);
        end
        n_checks++;
        if (log_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL overrun_count got %0d want %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL overrun_cmd[%0d] got %h want %h", i, log_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        int base_sv;
        slave_q.delete();
        for (int i = 0; i < 14; i++) slave_q.push_back(8'($urandom));
        log_q.delete();
        pulse_int();
        wait_log(11, 2000, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midrst_progress got %0d cmds want 11", log_q.size());
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({cmd_valid, sample_valid, init_done, busy, err_nack, err_timeout, overrun} !== 7'b0
            || sample_data !== 112'h0) begin
            n_fail++;
            $display("FAIL midrst_zero got flags=%b data=%h want 0",
                     {cmd_valid, sample_valid, init_done, busy, err_nack, err_timeout, overrun}, sample_data);
        end
        repeat (3) @(negedge clk);
        slave_q.delete();
        log_q.delete();
        exp_q.delete();
        exp_init();
        base_sv = sv_count;
        rst = 1'b0;
        wait_log(15, 3000, ok);
        wait_init_done(500, ok);
        repeat (20) @(negedge clk);
        n_checks++;
        if (init_done !== 1'b1 || log_q.size() != 15) begin
            n_fail++;
            $display("FAIL midrst_reinit got done=%b cmds=%0d want 1 15", init_done, log_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL midrst_cmd[%0d] got %h want %h", i, log_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (sv_count != base_sv || sample_data !== 112'h0) begin
            n_fail++;
            $display("FAIL midrst_nopublish got pulses=%0d data=%h want 0", sv_count - base_sv, sample_data);
        end
    endtask

    initial begin : main
        test_reset();
        test_single_read(1'b0);
        test_single_read(1'b1);
        test_nack();
        test_single_read(1'b1);
        test_timeout();
        test_overrun();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
